// File: rtl/oc8051_wbi_pkg.sv
// rtl/oc8051_wbi_pkg.sv - shared widths and FSM state type for the oc8051 instruction ROM slave
package oc8051_wbi_pkg;
  localparam int ADR_W = 16;
  localparam int DAT_W = 32;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;
endpackage

// File: rtl/oc8051_wbi_rom_slave_if.sv
// rtl/oc8051_wbi_rom_slave_if.sv - oc8051 instruction-side Wishbone classic bus bundle
interface oc8051_wbi_rom_slave_if;
  import oc8051_wbi_pkg::*;

  logic [ADR_W-1:0] wbi_adr_o;
  logic             wbi_cyc_o;
  logic             wbi_stb_o;
  logic [DAT_W-1:0] wbi_dat_i;
  logic             wbi_ack_i;
  logic             wbi_err_i;

  modport master (
    output wbi_adr_o, wbi_cyc_o, wbi_stb_o,
    input  wbi_dat_i, wbi_ack_i, wbi_err_i
  );

  modport slave (
    input  wbi_adr_o, wbi_cyc_o, wbi_stb_o,
    output wbi_dat_i, wbi_ack_i, wbi_err_i
  );
endinterface

// File: rtl/oc8051_byte_ram.sv
// rtl/oc8051_byte_ram.sv - byte ROM image, one write port, four combinational byte reads
module oc8051_byte_ram
  import oc8051_wbi_pkg::*;
#(
  parameter int DEPTH = 4096
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADR_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [ADR_W-1:0] raddr,
  output logic [DAT_W-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADR_W:0] DEPTH_X = (ADR_W+1)'(DEPTH);

  logic [7:0] mem [DEPTH];
  logic       unused_waddr;

  assign unused_waddr = ^waddr;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
  end

  // Lanes past the end of the ROM read as zero; the index is one bit wider so it never wraps.
  always_comb begin
    logic [ADR_W:0] idx;
    rdata = '0;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = {1'b0, raddr} + (ADR_W+1)'(k);
      if (idx < DEPTH_X) begin
        rdata[8*k +: 8] = mem[idx[AW-1:0]];
      end
    end
  end
endmodule

// File: rtl/oc8051_wbi_rom_slave.sv
// rtl/oc8051_wbi_rom_slave.sv - Wishbone classic ROM slave feeding oc8051 instruction fetches
module oc8051_wbi_rom_slave
  import oc8051_wbi_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int WAIT  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  oc8051_wbi_rom_slave_if.slave   wbi,
  input  logic                    prog_we,
  input  logic [ADR_W-1:0]        prog_addr,
  input  logic [7:0]              prog_data,
  output logic [15:0]             fetch_cnt
);
  localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;
  localparam logic [ADR_W:0]   DEPTH_X   = (ADR_W+1)'(DEPTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [DAT_W-1:0] dat_q, dat_d;
  logic [15:0]      fetch_cnt_q, fetch_cnt_d;

  logic             req;
  logic             enter_resp;
  logic             in_range;
  logic [ADR_W-1:0] rd_adr;
  logic [DAT_W-1:0] rd_word;

  // With no wait states the read happens on the same edge that latches the address.
  assign req      = wbi.wbi_cyc_o & wbi.wbi_stb_o;
  assign rd_adr   = (state_q == ST_IDLE) ? wbi.wbi_adr_o : adr_q;
  assign in_range = {1'b0, rd_adr} < DEPTH_X;

  oc8051_byte_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (rd_adr),
    .rdata (rd_word)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    adr_d       = adr_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    dat_d       = dat_q;
    fetch_cnt_d = fetch_cnt_q;
    enter_resp  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          adr_d = wbi.wbi_adr_o;
          if (WAIT == 0) begin
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (enter_resp) begin
      state_d = ST_RESP;
      ack_d   = in_range;
      err_d   = ~in_range;
      dat_d   = in_range ? rd_word : '0;
      if (in_range && fetch_cnt_q != 16'hFFFF) begin
        fetch_cnt_d = fetch_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      adr_q       <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      dat_q       <= '0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      adr_q       <= adr_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      dat_q       <= dat_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign wbi.wbi_ack_i = ack_q;
  assign wbi.wbi_err_i = err_q;
  assign wbi.wbi_dat_i = dat_q;
  assign fetch_cnt     = fetch_cnt_q;
endmodule

// File: tb/tb_oc8051_wbi_rom_slave.sv
// tb/tb_oc8051_wbi_rom_slave.sv - directed bench for oc8051_wbi_rom_slave at WAIT=0,1,3
module tb_oc8051_wbi_rom_slave;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_we = 1'b0;
  logic [15:0] prog_addr = '0;
  logic [7:0]  prog_data = '0;
  logic [15:0] fcnt0, fcnt1, fcnt3;
  int          checks = 0;
  int          errors = 0;

  oc8051_wbi_rom_slave_if b0 ();
  oc8051_wbi_rom_slave_if b1 ();
  oc8051_wbi_rom_slave_if b3 ();

  oc8051_wbi_rom_slave #(.DEPTH(4096), .WAIT(0)) u0 (
    .clk(clk), .rst(rst), .wbi(b0.slave), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .fetch_cnt(fcnt0));
  oc8051_wbi_rom_slave #(.DEPTH(4096), .WAIT(1)) u1 (
    .clk(clk), .rst(rst), .wbi(b1.slave), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .fetch_cnt(fcnt1));
  oc8051_wbi_rom_slave #(.DEPTH(4096), .WAIT(3)) u3 (
    .clk(clk), .rst(rst), .wbi(b3.slave), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .fetch_cnt(fcnt3));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic prog_byte(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  // One fetch on the WAIT=1 slave; reports edges from request to response.
  task automatic fetch1(input logic [15:0] a, output logic [31:0] dat, output int lat,
                        output logic ack, output logic err);
    @(posedge clk); #1;
    b1.wbi_adr_o = a; b1.wbi_cyc_o = 1'b1; b1.wbi_stb_o = 1'b1;
    lat = 0; ack = 1'b0; err = 1'b0; dat = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (b1.wbi_ack_i || b1.wbi_err_i) begin
        ack = b1.wbi_ack_i; err = b1.wbi_err_i; dat = b1.wbi_dat_i;
        break;
      end
    end
    b1.wbi_cyc_o = 1'b0; b1.wbi_stb_o = 1'b0;
    @(posedge clk); #1;
    check("resp_one_cycle", {30'd0, b1.wbi_ack_i, b1.wbi_err_i}, 32'd0);
  endtask

  logic [31:0] dat;
  int          lat;
  logic        ack, err;
  logic        seen;

  initial begin
    b0.wbi_adr_o = '0; b0.wbi_cyc_o = 1'b0; b0.wbi_stb_o = 1'b0;
    b1.wbi_adr_o = '0; b1.wbi_cyc_o = 1'b0; b1.wbi_stb_o = 1'b0;
    b3.wbi_adr_o = '0; b3.wbi_cyc_o = 1'b0; b3.wbi_stb_o = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, b1.wbi_ack_i}, 32'd0);
    check("rst_err", {31'd0, b1.wbi_err_i}, 32'd0);
    check("rst_dat", b1.wbi_dat_i, 32'd0);
    check("rst_cnt", {16'd0, fcnt1}, 32'd0);
    rst = 1'b0;

    prog_byte(16'h0000, 8'h02); prog_byte(16'h0001, 8'h00);
    prog_byte(16'h0002, 8'h30); prog_byte(16'h0003, 8'h75);
    prog_byte(16'h0004, 8'h66); prog_byte(16'h0005, 8'h77);
    prog_byte(16'h0006, 8'h88); prog_byte(16'h0007, 8'h99);
    prog_byte(16'h0010, 8'h11); prog_byte(16'h0011, 8'h22);
    prog_byte(16'h0012, 8'h33); prog_byte(16'h0013, 8'h44);
    prog_byte(16'h0014, 8'h55);
    prog_byte(16'h0FFE, 8'hAB); prog_byte(16'h0FFF, 8'hCD);

    // basic fetch, WAIT=1
    fetch1(16'h0000, dat, lat, ack, err);
    check("t1_ack", {31'd0, ack}, 32'd1);
    check("t1_lat", lat, 32'd2);
    check("t1_dat", dat, 32'h75300002);
    check("t1_cnt", {16'd0, fcnt1}, 32'd1);

    // back-to-back with WAIT=0: ack, idle gap, ack
    @(posedge clk); #1;
    b0.wbi_adr_o = 16'h0010; b0.wbi_cyc_o = 1'b1; b0.wbi_stb_o = 1'b1;
    @(posedge clk); #1;
    check("t2_ack_a", {31'd0, b0.wbi_ack_i}, 32'd1);
    check("t2_dat_a", b0.wbi_dat_i, 32'h44332211);
    b0.wbi_adr_o = 16'h0011;
    @(posedge clk); #1;
    check("t2_gap", {31'd0, b0.wbi_ack_i}, 32'd0);
    @(posedge clk); #1;
    check("t2_ack_b", {31'd0, b0.wbi_ack_i}, 32'd1);
    check("t2_dat_b", b0.wbi_dat_i, 32'h55443322);
    b0.wbi_cyc_o = 1'b0; b0.wbi_stb_o = 1'b0;
    @(posedge clk); #1;
    check("t2_cnt", {16'd0, fcnt0}, 32'd2);

    // out of range and end-of-ROM zero fill
    fetch1(16'h1000, dat, lat, ack, err);
    check("t3_err", {30'd0, ack, err}, 32'd1);
    check("t3_err_dat", dat, 32'd0);
    check("t3_err_cnt", {16'd0, fcnt1}, 32'd1);
    fetch1(16'h0FFE, dat, lat, ack, err);
    check("t3_edge_ack", {30'd0, ack, err}, 32'd2);
    check("t3_edge_dat", dat, 32'h0000CDAB);
    check("t3_edge_cnt", {16'd0, fcnt1}, 32'd2);

    // WAIT=3 abort after two cycles, then a full-latency fetch
    @(posedge clk); #1;
    b3.wbi_adr_o = 16'h0000; b3.wbi_cyc_o = 1'b1; b3.wbi_stb_o = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    b3.wbi_stb_o = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen = seen | b3.wbi_ack_i | b3.wbi_err_i;
    end
    b3.wbi_cyc_o = 1'b0;
    check("t4_no_resp", {31'd0, seen}, 32'd0);
    check("t4_abort_cnt", {16'd0, fcnt3}, 32'd0);
    @(posedge clk); #1;
    b3.wbi_cyc_o = 1'b1; b3.wbi_stb_o = 1'b1;
    lat = 0; ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (b3.wbi_ack_i) begin
        ack = 1'b1; dat = b3.wbi_dat_i;
        break;
      end
    end
    b3.wbi_cyc_o = 1'b0; b3.wbi_stb_o = 1'b0;
    check("t4_ack", {31'd0, ack}, 32'd1);
    check("t4_lat", lat, 32'd4);
    check("t4_dat", dat, 32'h75300002);

    // reset while in WAIT drops the request and keeps the ROM
    @(posedge clk); #1;
    b1.wbi_adr_o = 16'h0000; b1.wbi_cyc_o = 1'b1; b1.wbi_stb_o = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; b1.wbi_cyc_o = 1'b0; b1.wbi_stb_o = 1'b0;
    check("t5_ack", {30'd0, b1.wbi_ack_i, b1.wbi_err_i}, 32'd0);
    check("t5_dat", b1.wbi_dat_i, 32'd0);
    check("t5_cnt", {16'd0, fcnt1}, 32'd0);
    @(posedge clk); #1;
    check("t5_no_late_ack", {31'd0, b1.wbi_ack_i}, 32'd0);
    fetch1(16'h0000, dat, lat, ack, err);
    check("t5_refetch_lat", lat, 32'd2);
    check("t5_refetch_dat", dat, 32'h75300002);
    check("t5_refetch_cnt", {16'd0, fcnt1}, 32'd1);

    // write landing on the capture edge returns the old byte
    @(posedge clk); #1;
    b1.wbi_adr_o = 16'h0004; b1.wbi_cyc_o = 1'b1; b1.wbi_stb_o = 1'b1;
    @(posedge clk); #1;
    prog_we = 1'b1; prog_addr = 16'h0004; prog_data = 8'hAA;
    @(posedge clk); #1;
    prog_we = 1'b0; b1.wbi_cyc_o = 1'b0; b1.wbi_stb_o = 1'b0;
    check("t6_ack", {31'd0, b1.wbi_ack_i}, 32'd1);
    check("t6_old", b1.wbi_dat_i, 32'h99887766);
    fetch1(16'h0004, dat, lat, ack, err);
    check("t6_new", dat, 32'h998877AA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/oc8051_wbi_rom_slave.md
# oc8051_wbi_rom_slave

Wishbone classic slave that serves the oc8051 instruction bus (`wbi_*`) from a byte-organised program ROM. It replaces the hand-scripted per-cycle `wbi_dat_i`/`wbi_ack_i` stimulus that currently drives the core under simulation. A byte-wide programming port preloads the ROM. Each instruction fetch returns four consecutive bytes after a fixed number of wait states.

## Interface
Parameters:
- `DEPTH`, default 4096: ROM size in bytes. Must be a power of two, at most 65536.
- `WAIT`, default 1: wait-state cycles inserted between request detection and ack. Range 0..15.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `wbi_adr_o`  in  16: byte address from the core.
- `wbi_cyc_o`  in  1: bus cycle valid.
- `wbi_stb_o`  in  1: strobe.
- `wbi_dat_i`  out  32: fetched word, `{mem[a+3], mem[a+2], mem[a+1], mem[a]}`.
- `wbi_ack_i`  out  1: one-cycle acknowledge.
- `wbi_err_i`  out  1: one-cycle error, issued instead of ack.
- `prog_we`  in  1: ROM byte write enable.
- `prog_addr`  in  16: ROM write byte address.
- `prog_data`  in  8: ROM write data.
- `fetch_cnt`  out  16: count of acks issued. Saturates at 0xFFFF.

## Operation
- Request = `wbi_cyc_o & wbi_stb_o`.
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - If request and `WAIT==0`: latch address, go to RESP.
  - If request and `WAIT>0`: latch address, load wait counter with `WAIT-1`, go to WAIT.
- **WAIT**
  - If request deasserts: abort to IDLE; no ack, no err.
  - Else if counter is 0: go to RESP.
  - Else decrement the counter.
- **RESP**
  - Lasts exactly one cycle; always returns to IDLE.
  - Address handling in RESP uses the address latched in IDLE; later `wbi_adr_o` changes are ignored.
  - If latched address < `DEPTH`: assert `wbi_ack_i` and drive `wbi_dat_i`.
  - If latched address ≥ `DEPTH`: assert `wbi_err_i` instead of ack; `wbi_dat_i` = 0.
- Byte lanes: any byte index `a+k` ≥ `DEPTH` reads 0x00. There is no wrap-around.
- `wbi_dat_i` is registered. It holds its last value outside RESP.
- Programming: when `prog_we`, write `mem[prog_addr mod DEPTH] = prog_data` at the clock edge.
- `fetch_cnt` increments on each ack. Err responses do not count.

## Timing
- Reset values: `wbi_ack_i`=0, `wbi_err_i`=0, `wbi_dat_i`=0, `fetch_cnt`=0, FSM in IDLE, wait counter = 0.
- ROM contents are not affected by `rst`.
- Latency: ack is high in cycle N+1+WAIT, where N is the first cycle the request is sampled in IDLE.
- Throughput: with request held continuously, acks arrive every WAIT+2 cycles, because IDLE is re-entered for one cycle after each RESP.
- Read/write on the same cycle: data is captured on the edge entering RESP. A `prog_we` on that same edge is not visible; the read returns the old byte.
- `rst` asserted in any state: the FSM is in IDLE on the next cycle, with no ack/err and the counter cleared. A pending request is dropped; the master must restart it.
- Request deasserted during RESP: the ack is still issued (the response is already committed).
- Ack and err are never high together, and never for two consecutive cycles.

## Structure
- Package `oc8051_wbi_pkg` holds:
  - the FSM state enum (IDLE/WAIT/RESP);
  - address width 16 and data width 32;
  - wait-counter width 4.
- Sub-module `oc8051_byte_ram`: DEPTH×8 array, one write port and four combinational read ports (a..a+3, with zero-fill when an index is ≥ DEPTH). The FSM, counter, and output registers live in the top block.

## Test plan
1. Load `mem[0..3]` = 0x02, 0x00, 0x30, 0x75. With WAIT=1, fetch adr 0x0000 → ack 2 cycles after the request; `wbi_dat_i` = 0x75300002; `fetch_cnt` = 1.
2. WAIT=0, request held with adr 0x0010 then 0x0011 → acks on alternating cycles; data shifts by one byte between the two fetches.
3. DEPTH=4096, fetch adr 0x1000 → `wbi_err_i` for one cycle, `wbi_dat_i` = 0, `fetch_cnt` unchanged. Fetch adr 0x0FFE → ack; upper two bytes of the word = 0x00.
4. WAIT=3, drop `wbi_stb_o` after 2 cycles → no ack or err; FSM back in IDLE; the next request is acked with full latency.
5. Assert `rst` during WAIT → no ack; all outputs 0; ROM contents preserved, so a re-fetch returns the correct data.
6. `prog_we` to adr 0x0004 on the edge entering RESP for a fetch at adr 0x0004 → old byte returned; the next fetch returns the new byte.
